ysyx_lsu_store_buffer: RTL and testbench

//  Parametrised committed-store buffer between the commit stage and the LSU data bus.
//  - Holds SQ_SIZE retired stores in FIFO order and drains them oldest-first over a

---
 rtl/ysyx_lsu_store_buffer.sv | 160 ++++++++++++++++
 tb/tb_ysyx_lsu_store_buffer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_lsu_store_buffer.sv
// rtl/ysyx_lsu_store_buffer.sv - committed-store buffer: FIFO drain to the data bus, load forwarding, same-word coalescing
module ysyx_lsu_store_buffer #(
  parameter int SQ_SIZE  = 4,
  parameter int XLEN     = 32,
  parameter int COALESCE = 1,
  localparam int NB = XLEN / 8,
  localparam int IW = $clog2(SQ_SIZE),
  localparam int CW = IW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enq_valid,
  output logic            enq_ready,
  input  logic [XLEN-1:0] enq_addr,
  input  logic [XLEN-1:0] enq_data,
  input  logic [NB-1:0]   enq_wstrb,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [NB-1:0]   ld_rstrb,
  output logic            ld_fwd_hit,
  output logic [XLEN-1:0] ld_fwd_data,
  output logic            ld_stall,
  output logic            bus_wvalid,
  output logic [XLEN-1:0] bus_waddr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [NB-1:0]   bus_wstrb,
  input  logic            bus_wready,
  input  logic            bus_bvalid,
  output logic [CW-1:0]   sq_count,
  output logic            sq_empty
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            state;
  logic [SQ_SIZE-1:0] ent_valid;
  logic [XLEN-3:0]   ent_addr [SQ_SIZE];
  logic [XLEN-1:0]   ent_data [SQ_SIZE];
  logic [NB-1:0]     ent_strb [SQ_SIZE];
  logic [IW-1:0]     head;
  logic [IW-1:0]     tail;
  logic [IW-1:0]     youngest;
  logic [CW-1:0]     count;

  logic full;
  logic merge_ok;
  logic enq_fire;
  logic do_merge;
  logic do_new;
  logic do_pop;
  logic unused_addr_lsbs;

  assign youngest = tail - 1'b1;
  assign full     = (count == CW'(SQ_SIZE));

  // The head entry is frozen once the drain FSM has started presenting it on the bus.
  assign merge_ok = (COALESCE != 0) && ent_valid[youngest]
                 && (ent_addr[youngest] == enq_addr[XLEN-1:2])
                 && !((state != S_IDLE) && (youngest == head));

  assign enq_ready = !full || merge_ok;
  assign enq_fire  = enq_valid && enq_ready;
  assign do_merge  = enq_fire && merge_ok;
  assign do_new    = enq_fire && !merge_ok;
  assign do_pop    = (state == S_RESP) && bus_bvalid;

  assign bus_waddr = {ent_addr[head], 2'b00};
  assign bus_wdata = ent_data[head];
  assign bus_wstrb = ent_strb[head];
  assign sq_count  = count;
  assign sq_empty  = (count == '0);

  assign unused_addr_lsbs = ^{enq_addr[1:0], ld_addr[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid  <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      state      <= S_IDLE;
      bus_wvalid <= 1'b0;
    end else begin
      if (do_new) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (do_pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      count <= count + CW'(do_new) - CW'(do_pop);

      case (state)
        S_IDLE: begin
          if (ent_valid[head]) begin
            state      <= S_REQ;
            bus_wvalid <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_wready) begin
            state      <= S_RESP;
            bus_wvalid <= 1'b0;
          end
        end
        S_RESP: begin
          if (bus_bvalid) state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          bus_wvalid <= 1'b0;
        end
      endcase
    end
  end

  // Payload carries no reset: validity alone decides whether an entry is live.
  always_ff @(posedge clock) begin
    if (do_new) begin
      ent_addr[tail] <= enq_addr[XLEN-1:2];
      ent_data[tail] <= enq_data;
      ent_strb[tail] <= enq_wstrb;
    end else if (do_merge) begin
      for (int b = 0; b < NB; b++) begin
        if (enq_wstrb[b]) ent_data[youngest][8*b +: 8] <= enq_data[8*b +: 8];
      end
      ent_strb[youngest] <= ent_strb[youngest] | enq_wstrb;
    end
  end

  logic [IW-1:0] scan_idx;
  logic [NB-1:0] scan_ovl;
  logic          scan_found;

  // Youngest-to-oldest scan; the first overlapping entry decides hit versus stall.
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_stall    = 1'b0;
    ld_fwd_data = '0;
    scan_found  = 1'b0;
    scan_idx    = '0;
    scan_ovl    = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      scan_idx = tail + IW'(SQ_SIZE - 1 - i);
      scan_ovl = ent_strb[scan_idx] & ld_rstrb;
      if (!scan_found && ld_valid && ent_valid[scan_idx]
          && (ent_addr[scan_idx] == ld_addr[XLEN-1:2]) && (scan_ovl != '0)) begin
        scan_found = 1'b1;
        if (scan_ovl == ld_rstrb) begin
          ld_fwd_hit  = 1'b1;
          ld_fwd_data = ent_data[scan_idx];
        end else begin
          ld_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_store_buffer.sv
// tb/tb_ysyx_lsu_store_buffer.sv - randomized bench for ysyx_lsu_store_buffer against a queue-based store model
module tb_ysyx_lsu_store_buffer;
  localparam int SQ = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_wstrb;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rstrb;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        ld_stall;
  logic        bus_wvalid;
  logic [31:0] bus_waddr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_wready;
  logic        bus_bvalid;
  logic [2:0]  sq_count;
  logic        sq_empty;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_lsu_store_buffer #(.SQ_SIZE(SQ), .XLEN(32), .COALESCE(1)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_wstrb(enq_wstrb),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rstrb(ld_rstrb),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_wready(bus_wready), .bus_bvalid(bus_bvalid),
    .sq_count(sq_count), .sq_empty(sq_empty)
  );

  always #5 clock = ~clock;

  // Reference: committed stores as a plain queue, plus where the head store is in its bus life.
  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t mq[$];
  int   phase;  // 0 not yet offered, 1 request outstanding, 2 awaiting completion

  function automatic bit m_merge_ok(logic [31:0] a);
    if (mq.size() == 0) return 1'b0;
    if (mq[mq.size()-1].w != a[31:2]) return 1'b0;
    return !(mq.size() == 1 && phase != 0);
  endfunction

  function automatic bit m_ready(logic [31:0] a);
    return (mq.size() < SQ) || m_merge_ok(a);
  endfunction

  task automatic m_fwd(output bit h, output bit st, output logic [31:0] d);
    h = 0; st = 0; d = '0;
    if (ld_valid) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].w == ld_addr[31:2] && (mq[i].s & ld_rstrb) != 4'h0) begin
          if ((mq[i].s & ld_rstrb) == ld_rstrb) begin h = 1; d = mq[i].d; end
          else st = 1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    if (reset) begin
      mq.delete();
      phase = 0;
    end else begin
      bit acc, mrg, pop;
      ent_t e;
      acc = enq_valid && m_ready(enq_addr);
      mrg = acc && m_merge_ok(enq_addr);
      pop = (phase == 2) && bus_bvalid;
      case (phase)
        0: if (mq.size() > 0) phase = 1;
        1: if (bus_wready) phase = 2;
        default: if (bus_bvalid) phase = 0;
      endcase
      if (pop) void'(mq.pop_front());
      if (mrg) begin
        e = mq[mq.size()-1];
        for (int b = 0; b < 4; b++) if (enq_wstrb[b]) e.d[8*b +: 8] = enq_data[8*b +: 8];
        e.s = e.s | enq_wstrb;
        mq[mq.size()-1] = e;
      end else if (acc) begin
        e.w = enq_addr[31:2]; e.d = enq_data; e.s = enq_wstrb;
        mq.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    enq_valid = 0; enq_addr = '0; enq_data = '0; enq_wstrb = 4'h1;
    ld_valid = 0; ld_addr = '0; ld_rstrb = 4'h1;
    bus_wready = 0; bus_bvalid = 0;
  endtask

  task automatic drain();
    bus_wready = 1; bus_bvalid = 1; enq_valid = 0;
    for (int c = 0; c < 40 && mq.size() > 0; c++) tick();
    bus_wready = 0; bus_bvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    ld_valid = 1; ld_addr = 32'h8000_0000; ld_rstrb = 4'hF;
    tick(); tick();
    reset = 0;
    #1;
    n_checks++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready got %b want 1", enq_ready); else n_pass++;
    n_checks++; if (bus_wvalid !== 1'b0) $display("FAIL reset_bus_wvalid got %b want 0", bus_wvalid); else n_pass++;
    n_checks++; if (ld_fwd_hit !== 1'b0 || ld_stall !== 1'b0) $display("FAIL reset_fwd got hit=%b stall=%b want 0/0", ld_fwd_hit, ld_stall); else n_pass++;
    n_checks++; if (sq_count !== 3'd0) $display("FAIL reset_count got %0d want 0", sq_count); else n_pass++;
    n_checks++; if (sq_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", sq_empty); else n_pass++;
    ld_valid = 0;
  endtask

  task automatic test_single_store();
    enq_valid = 1; enq_addr = 32'h8000_0000; enq_data = 32'hDEAD_BEEF; enq_wstrb = 4'hF;
    #1;
    n_checks++; if (enq_ready !== 1'b1) $display("FAIL single_enq_ready got %b want 1", enq_ready); else n_pass++;
    tick();
    enq_valid = 0;
    #1;
    n_checks++; if (sq_count !== 3'd1 || sq_empty !== 1'b0) $display("FAIL single_count got %0d/%b want 1/0", sq_count, sq_empty); else n_pass++;
    n_checks++; if (bus_wvalid !== 1'b0) $display("FAIL single_wvalid_c1 got %b want 0", bus_wvalid); else n_pass++;
    tick();
    n_checks++; if (bus_wvalid !== 1'b1) $display("FAIL single_wvalid_c2 got %b want 1", bus_wvalid); else n_pass++;
    n_checks++; if (bus_waddr !== 32'h8000_0000 || bus_wstrb !== 4'hF || bus_wdata !== 32'hDEAD_BEEF)
      $display("FAIL single_bus got %h/%h/%h want 80000000/f/deadbeef", bus_waddr, bus_wstrb, bus_wdata); else n_pass++;
    bus_wready = 1;
    tick();
    bus_wready = 0; bus_bvalid = 1;
    #1;
    n_checks++; if (bus_wvalid !== 1'b0 || sq_empty !== 1'b0) $display("FAIL single_resp got wvalid=%b empty=%b want 0/0", bus_wvalid, sq_empty); else n_pass++;
    tick();
    bus_bvalid = 0;
    #1;
    n_checks++; if (sq_empty !== 1'b1) $display("FAIL single_empty_after got %b want 1", sq_empty); else n_pass++;
  endtask

  task automatic test_coalesce_forward();
    bus_wready = 0; bus_bvalid = 0;
    enq_valid = 1; enq_addr = 32'h8000_0004; enq_data = 32'h0000_0011; enq_wstrb = 4'h1;
    tick();
    enq_addr = 32'h8000_0005; enq_data = 32'h0000_2200; enq_wstrb = 4'h2;
    #1;
    n_checks++; if (enq_ready !== 1'b1) $display("FAIL coal_enq_ready got %b want 1", enq_ready); else n_pass++;
    tick();
    enq_valid = 0;
    #1;
    n_checks++; if (sq_count !== 3'd1) $display("FAIL coal_count got %0d want 1", sq_count); else n_pass++;
    n_checks++; if (bus_wdata[15:0] !== 16'h2211 || bus_wstrb !== 4'h3) $display("FAIL coal_entry got %h/%h want 2211/3", bus_wdata[15:0], bus_wstrb); else n_pass++;
    ld_valid = 1; ld_addr = 32'h8000_0004; ld_rstrb = 4'h3;
    #1;
    n_checks++; if (ld_fwd_hit !== 1'b1 || ld_stall !== 1'b0 || ld_fwd_data[15:0] !== 16'h2211)
      $display("FAIL fwd_lhu got hit=%b stall=%b data=%h want 1/0/2211", ld_fwd_hit, ld_stall, ld_fwd_data[15:0]); else n_pass++;
    ld_rstrb = 4'hF;
    #1;
    n_checks++; if (ld_stall !== 1'b1 || ld_fwd_hit !== 1'b0) $display("FAIL fwd_lw_stall got hit=%b stall=%b want 0/1", ld_fwd_hit, ld_stall); else n_pass++;
    ld_addr = 32'h8000_0008;
    #1;
    n_checks++; if (ld_fwd_hit !== 1'b0 || ld_stall !== 1'b0 || ld_fwd_data !== 32'h0)
      $display("FAIL fwd_miss got hit=%b stall=%b data=%h want 0/0/0", ld_fwd_hit, ld_stall, ld_fwd_data); else n_pass++;
    ld_valid = 0; ld_addr = 32'h8000_0004; ld_rstrb = 4'h3;
    #1;
    n_checks++; if (ld_fwd_hit !== 1'b0 || ld_fwd_data !== 32'h0) $display("FAIL fwd_invalid got hit=%b data=%h want 0/0", ld_fwd_hit, ld_fwd_data); else n_pass++;
    drain();
    #1;
    n_checks++; if (sq_empty !== 1'b1) $display("FAIL coal_drain got empty=%b want 1", sq_empty); else n_pass++;
  endtask

  task automatic test_full();
    bit accepted;
    bus_wready = 0; bus_bvalid = 0;
    for (int k = 0; k < 4; k++) begin
      enq_valid = 1; enq_addr = 32'h1000 + 32'(4 * k); enq_data = $urandom; enq_wstrb = 4'hF;
      #1;
      n_checks++; if (enq_ready !== 1'b1) $display("FAIL full_fill%0d got ready=%b want 1", k, enq_ready); else n_pass++;
      tick();
    end
    enq_valid = 0; enq_addr = 32'h2000;
    #1;
    n_checks++; if (enq_ready !== 1'b0 || sq_count !== 3'd4) $display("FAIL full_state got ready=%b count=%0d want 0/4", enq_ready, sq_count); else n_pass++;
    enq_addr = 32'h100C; enq_wstrb = 4'h2; enq_data = $urandom;
    #1;
    n_checks++; if (enq_ready !== 1'b1) $display("FAIL full_merge_ready got %b want 1", enq_ready); else n_pass++;
    enq_valid = 1;
    tick();
    n_checks++; if (sq_count !== 3'd4) $display("FAIL full_merge_count got %0d want 4", sq_count); else n_pass++;
    enq_addr = 32'h2000; enq_wstrb = 4'hF; enq_data = $urandom;
    bus_wready = 1; bus_bvalid = 1;
    accepted = 0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      #1;
      n_checks++; if (enq_ready !== (mq.size() < SQ)) $display("FAIL full_wait_ready got %b want %b", enq_ready, mq.size() < SQ); else n_pass++;
      accepted = (mq.size() < SQ);
      tick();
    end
    enq_valid = 0;
    n_checks++; if (!accepted || sq_count !== 3'd4) $display("FAIL full_refill got accepted=%b count=%0d want 1/4", accepted, sq_count); else n_pass++;
    drain();
  endtask

  task automatic test_wrap();
    logic [31:0] ea [9];
    logic [31:0] ed [9];
    logic [3:0]  es [9];
    int k, done;
    for (int i = 0; i < 9; i++) begin
      ea[i] = 32'h3000 + 32'(4 * i); ed[i] = $urandom; es[i] = 4'($urandom_range(1, 15));
    end
    k = 0; done = 0;
    for (int c = 0; c < 600 && done < 9; c++) begin
      enq_valid = (k < 9) && ($urandom_range(0, 3) != 0);
      if (k < 9) begin enq_addr = ea[k]; enq_data = ed[k]; enq_wstrb = es[k]; end
      bus_wready = $urandom_range(0, 1) == 1;
      bus_bvalid = $urandom_range(0, 1) == 1;
      #1;
      n_checks++; if (sq_count !== 3'(mq.size())) $display("FAIL wrap_count got %0d want %0d", sq_count, mq.size()); else n_pass++;
      if (bus_wvalid && bus_wready) begin
        n_checks++;
        if (done >= 9 || bus_waddr !== ea[done] || bus_wdata !== ed[done] || bus_wstrb !== es[done])
          $display("FAIL wrap_order%0d got %h/%h/%h want %h/%h/%h", done, bus_waddr, bus_wdata, bus_wstrb, ea[done % 9], ed[done % 9], es[done % 9]);
        else n_pass++;
        done++;
      end
      if (enq_valid && m_ready(enq_addr)) k++;
      tick();
    end
    n_checks++; if (done != 9) $display("FAIL wrap_done got %0d want 9", done); else n_pass++;
    idle_inputs();
    drain();
  endtask

  task automatic test_random();
    bit eh, es_;
    logic [31:0] ed;
    for (int c = 0; c < 300; c++) begin
      enq_valid  = $urandom_range(0, 9) < 6;
      enq_addr   = 32'h4000 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      enq_data   = $urandom;
      enq_wstrb  = 4'($urandom_range(1, 15));
      ld_valid   = $urandom_range(0, 3) != 0;
      ld_addr    = 32'h4000 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
      ld_rstrb   = 4'($urandom_range(1, 15));
      bus_wready = $urandom_range(0, 1) == 1;
      bus_bvalid = $urandom_range(0, 2) == 0;
      #1;
      m_fwd(eh, es_, ed);
      n_checks++; if (enq_ready !== m_ready(enq_addr)) $display("FAIL rnd_enq_ready c%0d got %b want %b", c, enq_ready, m_ready(enq_addr)); else n_pass++;
      n_checks++; if (sq_count !== 3'(mq.size()) || sq_empty !== (mq.size() == 0))
        $display("FAIL rnd_count c%0d got %0d/%b want %0d", c, sq_count, sq_empty, mq.size()); else n_pass++;
      n_checks++; if (bus_wvalid !== (phase == 1)) $display("FAIL rnd_wvalid c%0d got %b want %b", c, bus_wvalid, phase == 1); else n_pass++;
      if (phase == 1) begin
        n_checks++;
        if (bus_waddr !== {mq[0].w, 2'b00} || bus_wdata !== mq[0].d || bus_wstrb !== mq[0].s)
          $display("FAIL rnd_bus c%0d got %h/%h/%h want %h/%h/%h", c, bus_waddr, bus_wdata, bus_wstrb, {mq[0].w, 2'b00}, mq[0].d, mq[0].s);
        else n_pass++;
      end
      n_checks++;
      if (ld_fwd_hit !== eh || ld_stall !== es_ || ld_fwd_data !== ed)
        $display("FAIL rnd_fwd c%0d got %b/%b/%h want %b/%b/%h", c, ld_fwd_hit, ld_stall, ld_fwd_data, eh, es_, ed);
      else n_pass++;
      tick();
    end
    idle_inputs();
    drain();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      enq_valid = 1; enq_addr = 32'h5000 + 32'(4 * k); enq_data = $urandom; enq_wstrb = 4'hF;
      tick();
    end
    enq_valid = 0;
    bus_wready = 1;
    for (int c = 0; c < 10 && phase != 2; c++) tick();
    bus_wready = 0;
    #1;
    n_checks++; if (phase != 2 || sq_count !== 3'd3 || bus_wvalid !== 1'b0)
      $display("FAIL mid_setup got phase=%0d count=%0d wvalid=%b want 2/3/0", phase, sq_count, bus_wvalid); else n_pass++;
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_checks++; if (sq_count !== 3'd0 || bus_wvalid !== 1'b0 || sq_empty !== 1'b1)
      $display("FAIL mid_reset got count=%0d wvalid=%b empty=%b want 0/0/1", sq_count, bus_wvalid, sq_empty); else n_pass++;
    bus_bvalid = 1;
    tick();
    bus_bvalid = 0;
    tick();
    n_checks++; if (sq_count !== 3'd0 || bus_wvalid !== 1'b0) $display("FAIL mid_late_bvalid got count=%0d wvalid=%b want 0/0", sq_count, bus_wvalid); else n_pass++;
    enq_valid = 1; enq_addr = 32'h6000; enq_data = 32'h1234_5678; enq_wstrb = 4'hF;
    tick();
    enq_valid = 0;
    tick();
    n_checks++; if (bus_wvalid !== 1'b1) $display("FAIL mid_req got wvalid=%b want 1", bus_wvalid); else n_pass++;
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_checks++; if (bus_wvalid !== 1'b0 || sq_count !== 3'd0) $display("FAIL mid_req_reset got wvalid=%b count=%0d want 0/0", bus_wvalid, sq_count); else n_pass++;
  endtask

  initial begin
    phase = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_store();
    test_coalesce_forward();
    test_full();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
